// File: rtl/vscale_mem_arbiter.sv
// Fixed-priority imem/dmem arbiter onto one pipelined memory port.
// Optional imem anti-starvation: define VSCALE_MEM_ARB_FAIR_EN.
module vscale_mem_arbiter #(
  parameter int STARVE_LIMIT = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        imem_req,
  input  logic [31:0] imem_addr,
  output logic        imem_wait,
  output logic [31:0] imem_rdata,
  output logic        imem_badmem_e,
  input  logic        dmem_en,
  input  logic        dmem_wen,
  input  logic [2:0]  dmem_size,
  input  logic [31:0] dmem_addr,
  input  logic [31:0] dmem_wdata_delayed,
  output logic        dmem_wait,
  output logic [31:0] dmem_rdata,
  output logic        dmem_badmem_e,
  output logic        mem_en,
  output logic        mem_wen,
  output logic [2:0]  mem_size,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_wait,
  input  logic        mem_badmem_e
);

  typedef enum logic [1:0] {
    IDLE,
    IMEM,
    DMEM
  } owner_t;

  owner_t dp_owner;
  owner_t dp_owner_next;
  logic   accept;
  logic   grant_i;
  logic   grant_d;
  logic   force_i;

  assign accept = ~reset & ~((dp_owner != IDLE) & mem_wait);

`ifdef VSCALE_MEM_ARB_FAIR_EN
  localparam int CW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;

  logic [CW-1:0] starve;

  // Counter only moves on accepted cycles, so it freezes across stalls.
  assign force_i = accept & imem_req & dmem_en
                 & (starve == CW'(STARVE_LIMIT));

  always_ff @(posedge clk) begin
    if (reset) begin
      starve <= '0;
    end else if (accept) begin
      if (grant_i || !imem_req) begin
        starve <= '0;
      end else if (dmem_en) begin
        starve <= starve + 1'b1;
      end
    end
  end
`else
  logic unused_limit;

  assign unused_limit = ^STARVE_LIMIT;
  assign force_i = 1'b0;
`endif

  assign grant_d = accept & dmem_en & ~force_i;
  assign grant_i = accept & imem_req & (~dmem_en | force_i);

  always_ff @(posedge clk) begin
    if (reset) begin
      dp_owner <= IDLE;
    end else begin
      dp_owner <= dp_owner_next;
    end
  end

  always_comb begin
    dp_owner_next = dp_owner;
    mem_en        = 1'b0;
    mem_wen       = 1'b0;
    mem_size      = 3'd0;
    mem_addr      = 32'd0;
    mem_wdata     = 32'd0;
    imem_wait     = 1'b0;
    dmem_wait     = 1'b0;
    imem_rdata    = 32'd0;
    dmem_rdata    = 32'd0;
    imem_badmem_e = 1'b0;
    dmem_badmem_e = 1'b0;
    if (!reset) begin
      unique case (1'b1)
        grant_d: begin
          mem_en   = 1'b1;
          mem_wen  = dmem_wen;
          mem_size = dmem_size;
          mem_addr = dmem_addr;
        end
        grant_i: begin
          mem_en   = 1'b1;
          mem_size = 3'd2;
          mem_addr = imem_addr;
        end
        default: ;
      endcase
      if (accept) begin
        unique case (1'b1)
          grant_d: dp_owner_next = DMEM;
          grant_i: dp_owner_next = IMEM;
          default: dp_owner_next = IDLE;
        endcase
      end
      imem_wait = (imem_req & ~grant_i)
                | ((dp_owner == IMEM) & mem_wait);
      dmem_wait = (dmem_en & ~grant_d)
                | ((dp_owner == DMEM) & mem_wait);
      imem_rdata    = mem_rdata;
      dmem_rdata    = mem_rdata;
      imem_badmem_e = (dp_owner == IMEM) & mem_badmem_e;
      dmem_badmem_e = (dp_owner == DMEM) & mem_badmem_e;
      if (dp_owner == DMEM) begin
        mem_wdata = dmem_wdata_delayed;
      end
    end
  end

endmodule

// File: doc/vscale_mem_arbiter.md
# vscale_mem_arbiter

Fixed-priority, two-requester arbiter sharing one single-port pipelined memory between the core's instruction-fetch port and data port. It sits between the core and a unified memory. It grants each address phase to one requester and tracks which requester owns the following data phase. It routes read data, write data, stalls and bus errors to that owner. Uncontended accesses pass through with zero added latency.

## Interface
Parameters:
- STARVE_LIMIT, 3: number of consecutive contended cycles lost by imem before it is forced a grant. Used only with VSCALE_MEM_ARB_FAIR_EN.

Ports:
- clk  input  1  clock; all state updates on its rising edge.
- reset  input  1  reset; synchronous, active-high.
- imem_req  input  1  fetch address phase valid.
- imem_addr  input  32  fetch address.
- imem_wait  output  1  fetch stalled; the core holds imem_addr.
- imem_rdata  output  32  fetch data; valid in a data phase owned by imem.
- imem_badmem_e  output  1  fetch bus error.
- dmem_en  input  1  data address phase valid.
- dmem_wen  input  1  store.
- dmem_size  input  3  access size.
- dmem_addr  input  32  data address.
- dmem_wdata_delayed  input  32  store data, presented in the data phase.
- dmem_wait  output  1  data stalled.
- dmem_rdata  output  32  load data.
- dmem_badmem_e  output  1  data bus error.
- mem_en, mem_wen  output  1 each  shared-port address phase.
- mem_size  output  3  shared-port access size.
- mem_addr  output  32  shared-port address.
- mem_wdata  output  32  shared-port data-phase store data.
- mem_rdata  input  32  shared-port read data.
- mem_wait  input  1  shared-port stall.
- mem_badmem_e  input  1  shared-port bus error.

## Operation
- Data-phase owner register dp_owner: IDLE, IMEM or DMEM. It is cleared to IDLE on reset.
- An address phase is accepted only when the current data phase is not stalled: accept = ~(dp_owner != IDLE & mem_wait).
- Default priority is dmem over imem:
  - grant_d = accept & dmem_en
  - grant_i = accept & imem_req & ~dmem_en
- Shared-port address outputs:
  - on grant_d: mem_en=1, mem_wen/mem_size/mem_addr copied from the dmem port.
  - on grant_i: mem_en=1, mem_wen=0, mem_size=3'd2 (word), mem_addr=imem_addr.
  - otherwise: mem_en=0, mem_wen=0, mem_addr=0.
- dp_owner next state:
  - if mem_wait is high and dp_owner != IDLE: hold.
  - otherwise: DMEM on grant_d, IMEM on grant_i, else IDLE.
- Stall outputs:
  - imem_wait = (imem_req & ~grant_i) | (dp_owner==IMEM & mem_wait)
  - dmem_wait = (dmem_en & ~grant_d) | (dp_owner==DMEM & mem_wait)
- Data routing:
  - imem_rdata and dmem_rdata both equal mem_rdata.
  - badmem_e is routed only to the dp_owner requester; the other requester sees 0.
  - mem_wdata = dmem_wdata_delayed when dp_owner==DMEM, else 0.
- A write's data phase is never issued without its preceding address grant.

## Timing
- Grant and address outputs are combinational from the request inputs in the same cycle; there is no added latency.
- The data phase occupies the cycle after acceptance. Each cycle of mem_wait extends it by one cycle.
- Back-to-back accesses by either requester are sustained every cycle with no bubble.
- Simultaneous imem_req and dmem_en: dmem wins and imem_wait=1. imem re-arbitrates the next cycle, when dmem_en is low.
- mem_wait during a data phase: no new grant; both requesting ports see wait.
- Reset behaviour:
  - all outputs are forced to 0 while reset is high.
  - dp_owner becomes IDLE and the starvation counter becomes 0.
  - an in-flight data phase and mem_wait are dropped.

## Configuration
- VSCALE_MEM_ARB_FAIR_EN undefined: strict dmem priority; imem can starve indefinitely.
- VSCALE_MEM_ARB_FAIR_EN defined: adds a starvation counter (clog2(STARVE_LIMIT+1) bits).
  - it increments each accepted cycle in which imem_req and dmem_en are both high and dmem wins.
  - it clears on any grant_i, or when imem_req is low.
  - when it equals STARVE_LIMIT, the next contended accepted cycle grants imem, gives dmem_wait=1, and clears the counter.
  - it is frozen during mem_wait stalls.

## Test plan
- imem_req only, address 0x200, mem_rdata=0x00000013 -> mem_en=1, mem_size=2, mem_addr=0x200. Next cycle imem_rdata=0x13, imem_wait=0, dmem_badmem_e=0.
- Store with dmem_en=dmem_wen=1 to address 0x1004, then dmem_wdata_delayed=0xDEADBEEF -> mem_wdata=0xDEADBEEF in the data cycle, dp_owner=DMEM.
- Simultaneous imem_req and dmem load -> dmem granted, imem_wait=1 for that cycle. Next cycle with dmem_en=0: imem granted.
- mem_wait held for 3 cycles during an imem data phase with dmem_en=1 -> mem_en=0 and dmem_wait=1 for all 3 cycles. dmem is granted in the cycle mem_wait falls.
- mem_badmem_e=1 during a dmem data phase -> dmem_badmem_e=1, imem_badmem_e=0. Then reset asserted mid-mem_wait -> all outputs 0, and the next cycle arbitrates from IDLE.
- FAIR_EN defined, STARVE_LIMIT=3, both ports requesting continuously -> grant sequence D,D,D,I,D,D,D,I.
